// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - MIPS execute-stage multiply/divide unit owning HI/LO
// Ports:
//   clk    in   clock, all state updates on the rising edge
//   clr    in   synchronous active-high reset, aborts any operation in flight
//   start  in   E-stage instruction is a mul/div/mthi/mtlo op (qualifies op)
//   op     in   0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 no-op
//   cancel in   E-stage instruction is being flushed; blocks acceptance this cycle
//   a      in   rs operand: dividend / multiplicand / MTHI-MTLO data
//   b      in   rt operand: divisor / multiplier
//   busy   out  operation in progress, HI/LO not yet valid
//   hi     out  HI register
//   lo     out  LO register
module mul_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic        cancel,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAX_CYCLES + 1);

   localparam logic [CW-1:0] MULT_N  = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_N   = CW'(DIV_CYCLES);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] count;
   logic [31:0]   a_q, b_q;
   logic [2:0]    op_q;
   logic          accept, launch, finish;

   logic          is_signed;
   logic [31:0]   a_mag, b_mag, den, q_mag, r_mag, quo, rem;
   logic [63:0]   prod_s, prod_u;

   // Only IDLE accepts; a start seen while RUN is dropped, the hazard unit stalls it.
   assign accept = start && !cancel && (state == IDLE) && (op != 3'd0) && (op != 3'd7);
   assign launch = accept && (op <= OP_DIVU);

   // State register
   always_ff @(posedge clk) begin
      if (clr) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (launch) state_nx = RUN;
         RUN:     if (count == CNT_ONE) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy   = (state == RUN);
      finish = (state == RUN) && (count == CNT_ONE);
   end

   // Divide on magnitudes and restore signs afterwards so that the
   // 0x80000000 / -1 case needs no special handling: the magnitude
   // quotient 0x80000000 is already the architectural answer.
   always_comb begin
      is_signed = (op_q == OP_DIV);
      a_mag     = (is_signed && a_q[31]) ? (~a_q + 32'd1) : a_q;
      b_mag     = (is_signed && b_q[31]) ? (~b_q + 32'd1) : b_q;
      den       = (b_mag == 32'd0) ? 32'd1 : b_mag;   // result is discarded on /0
      q_mag     = a_mag / den;
      r_mag     = a_mag % den;
      quo       = (is_signed && (a_q[31] ^ b_q[31])) ? (~q_mag + 32'd1) : q_mag;
      rem       = (is_signed && a_q[31]) ? (~r_mag + 32'd1) : r_mag;
      // Low 64 bits of a sign-extended product equal the signed product.
      prod_s    = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
      prod_u    = {32'd0, a_q} * {32'd0, b_q};
   end

   // Operand latches, latency counter and HI/LO
   always_ff @(posedge clk) begin
      if (clr) begin
         a_q   <= 32'd0;
         b_q   <= 32'd0;
         op_q  <= 3'd0;
         count <= '0;
         hi    <= 32'd0;
         lo    <= 32'd0;
      end else begin
         if (launch) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            count <= (op <= OP_MULTU) ? MULT_N : DIV_N;
         end else if (state == RUN) begin
            count <= count - CNT_ONE;
         end

         if (accept && (op == OP_MTHI)) hi <= a;
         if (accept && (op == OP_MTLO)) lo <= a;

         if (finish) begin
            case (op_q)
               OP_MULT:  {hi, lo} <= prod_s;
               OP_MULTU: {hi, lo} <= prod_u;
               OP_DIV, OP_DIVU: begin
                  if (b_q != 32'd0) begin
                     hi <= rem;
                     lo <= quo;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        clr, start, cancel;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        busy;
   logic [31:0] hi, lo;

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] exp_hi = 32'd0;
   logic [31:0] exp_lo = 32'd0;

   mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .clr(clr), .start(start), .op(op), .cancel(cancel),
      .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   // Architectural reference: what HI/LO hold after the instruction retires.
   function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      longint          sx, sy, sp;
      longint unsigned ux, uy, up;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'd0, x};
      uy = {32'd0, y};
      case (o)
         3'd1: begin sp = sx * sy; exp_hi = sp[63:32]; exp_lo = sp[31:0]; end
         3'd2: begin up = ux * uy; exp_hi = up[63:32]; exp_lo = up[31:0]; end
         3'd3: if (y != 0) begin
                  sp = sx / sy; exp_lo = sp[31:0];
                  sp = sx % sy; exp_hi = sp[31:0];
               end
         3'd4: if (y != 0) begin exp_lo = x / y; exp_hi = x % y; end
         3'd5: exp_hi = x;
         3'd6: exp_lo = x;
         default: ;
      endcase
   endfunction

   function automatic int latency(input logic [2:0] o);
      return (o <= 3'd2) ? 5 : 10;
   endfunction

   // Issue one instruction at a negedge and follow it to retirement.
   // noise: drive random starts during RUN, which must all be ignored.
   task automatic do_op(input string name, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic can, input bit noise);
      bit          acc;
      int          n;
      logic [31:0] old_hi, old_lo;
      acc    = !can && (o >= 3'd1) && (o <= 3'd6);
      start  = 1'b1; op = o; a = x; b = y; cancel = can;
      @(negedge clk);
      if (acc && (o <= 3'd4)) begin
         n      = latency(o);
         old_hi = exp_hi;
         old_lo = exp_lo;
         for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            vectors++;
            if ({busy, hi, lo} !== {1'b1, old_hi, old_lo}) begin
               miscompares++;
               $display("FAIL %s busy cycle %0d: busy/hi/lo got %b/%h/%h want 1/%h/%h",
                        name, i, busy, hi, lo, old_hi, old_lo);
            end
            a = $urandom; b = $urandom;
            if (noise) begin
               start  = 1'b1;
               op     = 3'($urandom_range(0, 7));
               cancel = 1'($urandom_range(0, 1));
            end else begin
               start = 1'b0;
            end
         end
         model(o, x, y);
         @(negedge clk);
      end else if (acc) begin
         model(o, x, y);
      end
      vectors++;
      if ({busy, hi, lo} !== {1'b0, exp_hi, exp_lo}) begin
         miscompares++;
         $display("FAIL %s result: busy/hi/lo got %b/%h/%h want 0/%h/%h",
                  name, busy, hi, lo, exp_hi, exp_lo);
      end
      start = 1'b0; cancel = 1'b0; op = 3'd0;
   endtask

   task automatic test_reset();
      clr = 1'b1; start = 1'b0; cancel = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
      repeat (2) @(negedge clk);
      clr = 1'b0;
      exp_hi = 32'd0; exp_lo = 32'd0;
      vectors++;
      if ({busy, hi, lo} !== {1'b0, 32'd0, 32'd0}) begin
         miscompares++;
         $display("FAIL reset: busy/hi/lo got %b/%h/%h want 0/0/0", busy, hi, lo);
      end
   endtask

   task automatic test_mult();
      do_op("mult_neg2x3", 3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
      vectors++;
      if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin
         miscompares++;
         $display("FAIL mult_const: hi/lo got %h/%h want ffffffff/fffffffa", hi, lo);
      end
      do_op("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      vectors++;
      if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
         miscompares++;
         $display("FAIL multu_const: hi/lo got %h/%h want fffffffe/00000001", hi, lo);
      end
   endtask

   task automatic test_div();
      do_op("div_neg7by2", 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
      vectors++;
      if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
         miscompares++;
         $display("FAIL div_const: hi/lo got %h/%h want ffffffff/fffffffd", hi, lo);
      end
      do_op("divu_by0", 3'd4, 32'd7, 32'd0, 1'b0, 1'b0);
      do_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
      vectors++;
      if ({hi, lo} !== 64'h0000_0000_8000_0000) begin
         miscompares++;
         $display("FAIL div_ovf_const: hi/lo got %h/%h want 00000000/80000000", hi, lo);
      end
   endtask

   task automatic test_mthi_mtlo();
      do_op("mthi", 3'd5, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
      do_op("mtlo", 3'd6, 32'h9ABC_DEF0, 32'd0, 1'b0, 1'b0);
      do_op("mthi_cancel", 3'd5, 32'h5555_AAAA, 32'd0, 1'b1, 1'b0);
      do_op("mtlo_cancel", 3'd6, 32'hAAAA_5555, 32'd0, 1'b1, 1'b0);
      do_op("mult_cancel", 3'd1, 32'd9, 32'd9, 1'b1, 1'b0);
      do_op("op0", 3'd0, 32'hFFFF_0000, 32'd1, 1'b0, 1'b0);
      do_op("op7", 3'd7, 32'hFFFF_0000, 32'd1, 1'b0, 1'b0);
   endtask

   task automatic test_ignore_and_clr();
      do_op("pre_mthi", 3'd5, 32'h0BAD_F00D, 32'd0, 1'b0, 1'b0);
      start = 1'b1; op = 3'd1; a = 32'd7; b = 32'd9;
      @(negedge clk);                      // RUN cycle 1
      start = 1'b0;
      @(negedge clk);                      // RUN cycle 2
      start = 1'b1; op = 3'd6; a = 32'h0000_DEAD;
      @(negedge clk);                      // RUN cycle 3
      start = 1'b0; op = 3'd0;
      vectors++;
      if ({busy, hi, lo} !== {1'b1, exp_hi, exp_lo}) begin
         miscompares++;
         $display("FAIL ignored_start: busy/hi/lo got %b/%h/%h want 1/%h/%h",
                  busy, hi, lo, exp_hi, exp_lo);
      end
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      exp_hi = 32'd0; exp_lo = 32'd0;
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if ({busy, hi, lo} !== {1'b0, 32'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL clr_abort cycle %0d: busy/hi/lo got %b/%h/%h want 0/0/0",
                     i, busy, hi, lo);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      do_op("b2b_mult", 3'd1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b1);
      do_op("b2b_div", 3'd3, 32'd100, 32'hFFFF_FFF9, 1'b0, 1'b1);
      do_op("b2b_mtlo", 3'd6, 32'hCAFE_BABE, 32'd0, 1'b0, 1'b0);
      do_op("b2b_divu", 3'd4, 32'hFFFF_FFFF, 32'd16, 1'b0, 1'b0);
      do_op("b2b_multu", 3'd2, 32'h8000_0000, 32'd2, 1'b0, 1'b1);
   endtask

   task automatic test_random();
      logic [2:0]  o;
      logic [31:0] x, y;
      logic        can;
      for (int i = 0; i < 60; i++) begin
         o   = 3'($urandom_range(0, 7));
         x   = $urandom;
         y   = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
         if ($urandom_range(0, 3) == 0) y = 32'($urandom_range(0, 15)) - 32'd8;
         can = ($urandom_range(0, 5) == 0);
         do_op("random", o, x, y, can, 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_mthi_mtlo();
      test_ignore_and_clr();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
